// File: rtl/addr_ch_gen.sv
// Address channel generator: decodes requests for one destination, turns the type and offset into an
// absolute DDR command, checks it against the region span, and queues it in a FIFO that the consumer drains.
module addr_ch_gen #(
    parameter logic [7:0]              POS_1ST    = 8'h00,
    parameter logic [2:0]              POS_2ND    = 3'd0,
    parameter int                      TYPE_NUM   = 4,
    parameter int                      OFFSET_W   = 20,
    parameter logic [30*TYPE_NUM-1:0]  BASE_TABLE = {TYPE_NUM{30'h0}},
    parameter logic [30*TYPE_NUM-1:0]  LEN_TABLE  = {TYPE_NUM{30'h0}},
    parameter logic [30*TYPE_NUM-1:0]  SPAN_TABLE = {TYPE_NUM{30'h0}},
    parameter int                      FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                request_valid_i,
    output logic                request_ready_o,
    input  logic [7:0]          request_pos_1st_i,
    input  logic [2:0]          request_pos_2nd_i,
    input  logic [2:0]          request_src_type_i,
    input  logic [OFFSET_W-1:0] request_access_addr_i,
    input  logic                rd_en,
    output logic [74:0]         dout,
    output logic                valid,
    output logic                empty,
    output logic                full,
    output logic                err_o,
    output logic [15:0]         drop_cnt_o
);

    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam int         CNT_W    = PTR_W + 1;
    localparam logic [2:0] TYPE_MAX = 3'(TYPE_NUM);

    // ---------------- request decode / stage 1 ----------------
    logic                w_match;
    logic                w_accept;
    logic                r_s1_vld;
    logic [2:0]          r_s1_type;
    logic [OFFSET_W-1:0] r_s1_off;

    assign w_match  = request_valid_i && (request_pos_1st_i == POS_1ST) && (request_pos_2nd_i == POS_2ND);
    assign w_accept = w_match && request_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_type <= 3'd0;
            r_s1_off  <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_type <= request_src_type_i;
                r_s1_off  <= request_access_addr_i;
            end
        end
    end

    // ---------------- table lookup ----------------
    // Tables are padded to all eight type codes so any 3-bit index is in range; unused slots read zero.
    logic [29:0] w_base_tab [8];
    logic [29:0] w_len_tab  [8];
    logic [29:0] w_span_tab [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tab
            if (gi < TYPE_NUM) begin : g_used
                assign w_base_tab[gi] = BASE_TABLE[30*gi +: 30];
                assign w_len_tab[gi]  = LEN_TABLE[30*gi +: 30];
                assign w_span_tab[gi] = SPAN_TABLE[30*gi +: 30];
            end else begin : g_unused
                assign w_base_tab[gi] = 30'h0;
                assign w_len_tab[gi]  = 30'h0;
                assign w_span_tab[gi] = 30'h0;
            end
        end
    endgenerate

    logic [2:0]  w_idx;
    logic        w_type_ok;
    logic [30:0] w_end;
    logic        w_span_ok;
    logic [29:0] w_start;

    assign w_idx     = r_s1_type - 3'd1;
    assign w_type_ok = (r_s1_type != 3'd0) && (r_s1_type <= TYPE_MAX);
    // One extra bit so offset+length cannot wrap before the span comparison.
    assign w_end     = {{(31-OFFSET_W){1'b0}}, r_s1_off} + {1'b0, w_len_tab[w_idx]};
    assign w_span_ok = w_end <= {1'b0, w_span_tab[w_idx]};
    assign w_start   = w_base_tab[w_idx] + {{(30-OFFSET_W){1'b0}}, r_s1_off};

    // ---------------- stage 2 ----------------
    logic        r_s2_vld;
    logic        r_s2_ok;
    logic [2:0]  r_s2_type;
    logic [29:0] r_s2_start;
    logic [29:0] r_s2_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld   <= 1'b0;
            r_s2_ok    <= 1'b0;
            r_s2_type  <= 3'd0;
            r_s2_start <= 30'h0;
            r_s2_len   <= 30'h0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_ok    <= w_type_ok && w_span_ok;
                r_s2_type  <= r_s1_type;
                r_s2_start <= w_start;
                r_s2_len   <= w_len_tab[w_idx];
            end
        end
    end

    // ---------------- drop accounting ----------------
    logic        w_wr;
    logic        w_drop;
    logic        r_err;
    logic [15:0] r_drop_cnt;

    assign w_wr   = r_s2_vld && r_s2_ok;
    assign w_drop = r_s2_vld && !r_s2_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_drop_cnt <= 16'h0;
        end else begin
            r_err <= w_drop;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign err_o      = r_err;
    assign drop_cnt_o = r_drop_cnt;

    // ---------------- command FIFO ----------------
    logic [62:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [74:0]      r_dout;
    logic             r_valid;
    logic             w_rd;
    logic [CNT_W:0]   w_occupancy;

    assign w_rd = rd_en && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_s2_len, r_s2_start, r_s2_type};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= 75'h0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_dout   <= {r_mem[r_rd_ptr], POS_2ND, POS_1ST, 1'b1};
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Commands still in the pipeline reserve a slot, so a write never lands on a full FIFO.
    assign w_occupancy     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_vld} + {{CNT_W{1'b0}}, r_s2_vld};
    assign request_ready_o = w_occupancy < (CNT_W+1)'(FIFO_DEPTH);

    assign dout  = r_dout;
    assign valid = r_valid;
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_addr_ch_gen.sv
// Bench for addr_ch_gen: directed latency/boundary/backpressure/reset cases plus a random run,
// all checked against a queue-based transaction model computed from the address rules.
`timescale 1ns/1ps
module tb_addr_ch_gen;

    localparam logic [7:0]   P1    = 8'h5A;
    localparam logic [2:0]   P2    = 3'd3;
    localparam int           TN    = 4;
    localparam int           OW    = 20;
    localparam int           DEPTH = 4;
    localparam logic [119:0] BASE_T = {30'h3FE00000, 30'h2000000, 30'h1020000, 30'h1000000};
    localparam logic [119:0] LEN_T  = {30'd1, 30'h100000, 30'd512, 30'd256};
    localparam logic [119:0] SPAN_T = {4{30'h100000}};

    longint ref_base [4] = '{64'h1000000, 64'h1020000, 64'h2000000, 64'h3FE00000};
    longint ref_len  [4] = '{256, 512, 64'h100000, 1};
    longint ref_span [4] = '{64'h100000, 64'h100000, 64'h100000, 64'h100000};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          request_valid_i = 1'b0;
    logic          request_ready_o;
    logic [7:0]    request_pos_1st_i = 8'h0;
    logic [2:0]    request_pos_2nd_i = 3'h0;
    logic [2:0]    request_src_type_i = 3'h0;
    logic [OW-1:0] request_access_addr_i = '0;
    logic          rd_en = 1'b0;
    logic [74:0]   dout;
    logic          valid;
    logic          empty;
    logic          full;
    logic          err_o;
    logic [15:0]   drop_cnt_o;

    addr_ch_gen #(
        .POS_1ST(P1), .POS_2ND(P2), .TYPE_NUM(TN), .OFFSET_W(OW),
        .BASE_TABLE(BASE_T), .LEN_TABLE(LEN_T), .SPAN_TABLE(SPAN_T), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .request_valid_i(request_valid_i), .request_ready_o(request_ready_o),
        .request_pos_1st_i(request_pos_1st_i), .request_pos_2nd_i(request_pos_2nd_i),
        .request_src_type_i(request_src_type_i), .request_access_addr_i(request_access_addr_i),
        .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty), .full(full),
        .err_o(err_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [74:0] exp_q [$];
    int          exp_drops = 0;
    int          err_seen  = 0;

    always @(negedge clk) if (rst_n && err_o) err_seen++;

    task automatic chk(input string tag, input logic [74:0] got, input logic [74:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected command word, or 0 when the request must be dropped.
    function automatic bit ref_eval(input int t, input longint off, output logic [74:0] w);
        longint start;
        w = '0;
        if (t < 1 || t > TN) return 1'b0;
        if (off + ref_len[t-1] > ref_span[t-1]) return 1'b0;
        start = (ref_base[t-1] + off) % (64'd1 << 30);
        w = {30'(ref_len[t-1]), 30'(start), 3'(t), P2, P1, 1'b1};
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input int t, input int off);
        logic [74:0] w;
        if (ref_eval(t, off, w)) exp_q.push_back(w);
        else exp_drops++;
    endtask

    task automatic send(input logic [7:0] p1, input logic [2:0] p2, input int t, input int off);
        bit acc;
        request_valid_i       = 1'b1;
        request_pos_1st_i     = p1;
        request_pos_2nd_i     = p2;
        request_src_type_i    = 3'(t);
        request_access_addr_i = OW'(off);
        if (!(p1 == P1 && p2 == P2)) begin
            step();
            request_valid_i = 1'b0;
            return;
        end
        for (int k = 0; k < 40; k++) begin
            acc = request_ready_o;
            step();
            if (acc) begin
                request_valid_i = 1'b0;
                model_accept(t, off);
                $display("[TB] req type=%0d off=%05h accepted", t, off);
                return;
            end
        end
        chk("send_timeout", request_ready_o, 1'b1);
        request_valid_i = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [74:0] w;
        if (exp_q.size() == 0) begin
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
            chk({tag, "_empty_valid"}, valid, 1'b0);
            return;
        end
        for (int k = 0; k < 8 && empty; k++) step();
        chk({tag, "_wait_data"}, empty, 1'b0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        w = exp_q.pop_front();
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_dout"}, dout, w);
        $display("[TB] pop dout=%019h expected=%019h", dout, w);
    endtask

    task automatic check_drops(input string tag);
        repeat (3) step();
        chk({tag, "_drop_cnt"}, drop_cnt_o, exp_drops);
        chk({tag, "_err_pulses"}, err_seen, exp_drops);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [74:0] held;
        int sent;
        int t, off;
        logic [7:0] p1;

        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_ready", request_ready_o, 1'b1);
        chk("rst_valid", valid, 1'b0);
        chk("rst_dout", dout, 75'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_drop", drop_cnt_o, 16'h0);

        // Latency of a single good request and its popped fields.
        send(P1, P2, 1, 'h00100);
        chk("lat_n", empty, 1'b1);
        step();
        chk("lat_n1", empty, 1'b1);
        step();
        chk("lat_n2", empty, 1'b0);
        pop_chk("t1");
        held = dout;
        chk("t1_start", 75'(held[44:15]), 75'h1000100);
        chk("t1_len", 75'(held[74:45]), 75'd256);
        chk("t1_type", 75'(held[14:12]), 75'd1);
        step();
        chk("t1_valid_once", valid, 1'b0);
        chk("t1_dout_hold", dout, held);
        chk("t1_empty", empty, 1'b1);

        // Non-matching positions are ignored; type 0 is dropped.
        send(8'h11, P2, 1, 0);
        send(P1, 3'd5, 1, 0);
        check_drops("nomatch");
        chk("nomatch_empty", empty, 1'b1);
        send(P1, P2, 0, 0);
        check_drops("type0");

        // Span overflow and boundary cases.
        send(P1, P2, 2, 'hFFF00);
        check_drops("span");
        chk("span_empty", empty, 1'b1);
        send(P1, P2, 3, 0);
        send(P1, P2, 3, 1);
        send(P1, P2, 4, 'hFFFFF);
        send(P1, P2, 6, 0);
        check_drops("bound");
        pop_chk("bound_a");
        pop_chk("bound_b");

        // Backpressure with no reads.
        for (int i = 0; i < 4; i++) send(P1, P2, 1, i * 16);
        chk("fill_ready", request_ready_o, 1'b0);
        request_valid_i       = 1'b1;
        request_src_type_i    = 3'd2;
        request_access_addr_i = OW'(20'h40);
        repeat (4) step();
        chk("fill_full", full, 1'b1);
        chk("fill_ready_held", request_ready_o, 1'b0);
        pop_chk("fill_pop");
        for (int k = 0; k < 10; k++) begin
            if (request_ready_o) begin
                step();
                break;
            end
            step();
        end
        request_valid_i = 1'b0;
        model_accept(2, 'h40);
        repeat (3) step();
        chk("refill_full", full, 1'b1);
        repeat (4) pop_chk("fill_drain");

        // Simultaneous read and write at count 2.
        send(P1, P2, 1, 'h10);
        send(P1, P2, 2, 'h20);
        repeat (3) step();
        send(P1, P2, 4, 'h30);
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        held = exp_q.pop_front();
        chk("rw_valid", valid, 1'b1);
        chk("rw_dout", dout, held);
        chk("rw_empty", empty, 1'b0);
        chk("rw_full", full, 1'b0);
        pop_chk("rw_a");
        pop_chk("rw_b");
        chk("rw_empty_end", empty, 1'b1);
        held = dout;
        pop_chk("rd_on_empty");
        chk("rd_on_empty_dout", dout, held);

        // Random traffic with interleaved reads.
        sent = 0;
        while (sent < 32) begin
            if (exp_q.size() >= 3 || (exp_q.size() > 0 && $urandom_range(0, 2) == 0)) begin
                pop_chk("rnd");
            end else begin
                p1  = ($urandom_range(0, 7) == 0) ? (P1 ^ 8'($urandom_range(1, 255))) : P1;
                t   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
                off = ($urandom_range(0, 3) == 0) ? int'(20'hFFFFF - $urandom_range(0, 600))
                                                  : int'($urandom_range(0, 20'hFFFFF));
                send(p1, P2, t, off);
                sent++;
            end
        end
        while (exp_q.size() > 0) pop_chk("rnd_drain");
        check_drops("rnd");

        // Reset with queued and in-flight commands.
        send(P1, P2, 1, 'h1);
        send(P1, P2, 2, 'h2);
        repeat (3) step();
        send(P1, P2, 3, 0);
        send(P1, P2, 4, 'h5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        exp_drops = 0;
        err_seen  = 0;
        chk("mrst_empty", empty, 1'b1);
        chk("mrst_ready", request_ready_o, 1'b1);
        chk("mrst_drop", drop_cnt_o, 16'h0);
        chk("mrst_valid", valid, 1'b0);
        repeat (5) step();
        chk("mrst_no_write", empty, 1'b1);
        chk("mrst_no_err", err_seen, 0);
        send(P1, P2, 2, 'h123);
        pop_chk("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
